// File: rtl/score_pkg.sv
// ============================================================================
// Module  : score_pkg
// Purpose : Shared types and 7-segment constants for the score_board block.
//           Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package score_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    WON  = 1'b1
  } game_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

`default_nettype wire

// File: rtl/seg7_digit.sv
// ============================================================================
// Module  : seg7_digit
// Purpose : Combinational decimal-digit to active-low 7-segment decoder.
//           Values above 9 show a blank digit.
// Ports   : value  in  4  binary digit value
//           seg    out 7  active-low segments {g..a}
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_digit
  import score_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    for (int d = 0; d < 10; d++) begin
      if (value == 4'(d)) seg = SEG_DIGIT[d];
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_board.sv
// ============================================================================
// Module  : score_board
// Purpose : N-player point tally for the reaction game. Credits one point per
//           qualifying press (lit target + rising key edge), ends the game at
//           MAX_SCORE, reports the 1-based winner and drives one 7-seg digit
//           per player.
// Ports   : Clock      in   1                    system clock
//           reset      in   1                    async active-high reset
//           new_game   in   1                    sync clear back to PLAY
//           light      in   NUM_PLAYERS          per-player target-lit qualifier
//           KEY        in   NUM_PLAYERS          per-player press, synchronised
//           score      out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs
//           game_over  out  1                    high while in WON
//           winner     out  PID_W                1-based winner, 0 = none
//           HEX        out  NUM_PLAYERS*7        packed active-low digits
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module score_board
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int MAX_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int PID_W       = 3
) (
  input  logic                           Clock,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic [NUM_PLAYERS-1:0]         light,
  input  logic [NUM_PLAYERS-1:0]         KEY,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic                           game_over,
  output logic [PID_W-1:0]               winner,
  output logic [NUM_PLAYERS*7-1:0]       HEX
);

  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  if (MAX_SCORE > 9) begin : g_chk_max
    $error("score_board: MAX_SCORE must not exceed 9");
  end
  if ((2 ** SCORE_W) <= MAX_SCORE) begin : g_chk_score_w
    $error("score_board: SCORE_W too narrow for MAX_SCORE");
  end
  if ((2 ** PID_W) <= NUM_PLAYERS) begin : g_chk_pid_w
    $error("score_board: PID_W too narrow for NUM_PLAYERS");
  end

  game_state_t              state, state_d;
  logic [NUM_PLAYERS-1:0]   key_q;
  logic [SCORE_W-1:0]       scores [NUM_PLAYERS];
  logic [PID_W-1:0]         winner_q;

  logic [NUM_PLAYERS-1:0]   hit;
  logic [NUM_PLAYERS-1:0]   grant;
  logic                     win_now;
  logic [PID_W-1:0]         win_id;
  logic                     found;

  assign hit = light & KEY & ~key_q;

  // Priority select plus next-state. Only the lowest-index hit is considered;
  // higher hits in the same cycle are simply dropped, not queued.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_now = 1'b0;
    win_id  = '0;
    state_d = state;
    if (state == PLAY && !new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (hit[i] && !found) begin
          found = 1'b1;
          if (scores[i] < MAX_S) begin
            grant[i] = 1'b1;
            if (scores[i] == MAX_S - 1'b1) begin
              win_now = 1'b1;
              win_id  = PID_W'(i + 1);
            end
          end
        end
      end
    end
    if (new_game) begin
      state_d = PLAY;
    end else if (win_now) begin
      state_d = WON;
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      key_q    <= '0;
      winner_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) scores[i] <= '0;
    end else begin
      // key_q tracks KEY even during new_game so a held key cannot score later.
      key_q <= KEY;
      state <= state_d;
      if (new_game) begin
        winner_q <= '0;
        for (int i = 0; i < NUM_PLAYERS; i++) scores[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (grant[i]) scores[i] <= scores[i] + 1'b1;
        end
        if (win_now) winner_q <= win_id;
      end
    end
  end

  assign game_over = (state == WON);
  assign winner    = winner_q;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_digit
    logic [3:0] val;
    assign score[i*SCORE_W +: SCORE_W] = scores[i];
    // Anything outside the legal score range decodes to blank.
    assign val = (scores[i] <= MAX_S) ? 4'(scores[i]) : 4'hF;
    seg7_digit u_seg (
      .value (val),
      .seg   (HEX[i*7 +: 7])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_score_board.sv
// ============================================================================
// Module  : tb_score_board
// Purpose : Scoreboard bench for score_board. Instance A: 3 players, max 3.
//           Instance B: 2 players, max 9 (saturation).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_board;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       ng_a = 1'b0;
  logic [2:0] light_a = '0, key_a = '0;
  logic [11:0] score_a;
  logic        go_a;
  logic [2:0]  win_a;
  logic [20:0] hex_a;

  logic       ng_b = 1'b0;
  logic [1:0] light_b = '0, key_b = '0;
  logic [7:0]  score_b;
  logic        go_b;
  logic [2:0]  win_b;
  logic [13:0] hex_b;

  always #5 clk = ~clk;

  score_board #(.NUM_PLAYERS(3), .MAX_SCORE(3), .SCORE_W(4), .PID_W(3)) dut_a (
    .Clock(clk), .reset(rst), .new_game(ng_a), .light(light_a), .KEY(key_a),
    .score(score_a), .game_over(go_a), .winner(win_a), .HEX(hex_a)
  );

  score_board #(.NUM_PLAYERS(2), .MAX_SCORE(9), .SCORE_W(4), .PID_W(3)) dut_b (
    .Clock(clk), .reset(rst), .new_game(ng_b), .light(light_b), .KEY(key_b),
    .score(score_b), .game_over(go_b), .winner(win_b), .HEX(hex_b)
  );

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] score;
    logic        go;
    logic [2:0]  win;
    logic [63:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push_a(input string nm, input int s0, input int s1, input int s2,
                        input logic go, input int w);
    exp_t e;
    e.name  = nm;
    e.dut   = 0;
    e.score = {20'd0, 4'(s2), 4'(s1), 4'(s0)};
    e.go    = go;
    e.win   = 3'(w);
    e.hex   = {43'd0, seg(s2), seg(s1), seg(s0)};
    exp_q.push_back(e);
  endtask

  task automatic push_b(input string nm, input int s0, input int s1,
                        input logic go, input int w);
    exp_t e;
    e.name  = nm;
    e.dut   = 1;
    e.score = {24'd0, 4'(s1), 4'(s0)};
    e.go    = go;
    e.win   = 3'(w);
    e.hex   = {50'd0, seg(s1), seg(s0)};
    exp_q.push_back(e);
  endtask

  // Monitor: pops each expectation as soon as it is queued and compares it
  // against the live outputs of the selected instance.
  initial begin
    exp_t        e;
    logic [31:0] a_sc;
    logic        a_go;
    logic [2:0]  a_win;
    logic [63:0] a_hex;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        a_sc = {20'd0, score_a}; a_go = go_a; a_win = win_a; a_hex = {43'd0, hex_a};
      end else begin
        a_sc = {24'd0, score_b}; a_go = go_b; a_win = win_b; a_hex = {50'd0, hex_b};
      end
      n_tests++;
      if (a_sc !== e.score || a_go !== e.go || a_win !== e.win || a_hex !== e.hex) begin
        n_fail++;
        $display("FAIL %s: got score=%h go=%b win=%0d hex=%h, expected score=%h go=%b win=%0d hex=%h",
                 e.name, a_sc, a_go, a_win, a_hex, e.score, e.go, e.win, e.hex);
      end
    end
  end

  // Each call is entered just after a rising edge; inputs are sampled at the
  // next edge and the task returns 1 time unit after it.
  task automatic cyc_a(input logic [2:0] l, input logic [2:0] k, input logic ng);
    light_a = l; key_a = k; ng_a = ng;
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic [1:0] l, input logic [1:0] k);
    light_b = l; key_b = k;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_a("reset_a", 0, 0, 0, 1'b0, 0);
    push_b("reset_b", 0, 0, 1'b0, 0);

    // Edge detect: held key scores once.
    cyc_a(3'b010, 3'b010, 1'b0);
    push_a("held_first", 0, 1, 0, 1'b0, 0);
    repeat (4) cyc_a(3'b010, 3'b010, 1'b0);
    push_a("held_5cyc", 0, 1, 0, 1'b0, 0);
    cyc_a(3'b010, 3'b000, 1'b0);
    cyc_a(3'b000, 3'b010, 1'b0);
    push_a("press_unlit", 0, 1, 0, 1'b0, 0);
    cyc_a(3'b010, 3'b010, 1'b0);
    push_a("light_rise_held", 0, 1, 0, 1'b0, 0);
    cyc_a(3'b000, 3'b000, 1'b0);

    // Simultaneous hits: lowest index wins, others dropped.
    cyc_a(3'b111, 3'b110, 1'b0);
    push_a("simul_hits", 0, 2, 0, 1'b0, 0);
    cyc_a(3'b111, 3'b000, 1'b0);

    // Player 3 (index 2) wins with three presses.
    cyc_a(3'b100, 3'b100, 1'b0); push_a("p2_press1", 0, 2, 1, 1'b0, 0);
    cyc_a(3'b100, 3'b000, 1'b0);
    cyc_a(3'b100, 3'b100, 1'b0); push_a("p2_press2", 0, 2, 2, 1'b0, 0);
    cyc_a(3'b100, 3'b000, 1'b0);
    cyc_a(3'b100, 3'b100, 1'b0); push_a("p2_win", 0, 2, 3, 1'b1, 3);
    cyc_a(3'b111, 3'b000, 1'b0);
    cyc_a(3'b111, 3'b111, 1'b0); push_a("won_frozen", 0, 2, 3, 1'b1, 3);
    cyc_a(3'b111, 3'b000, 1'b0);

    // new_game overrides a same-cycle hit; held key does not score after.
    cyc_a(3'b001, 3'b001, 1'b1); push_a("new_game", 0, 0, 0, 1'b0, 0);
    cyc_a(3'b001, 3'b001, 1'b0); push_a("held_thru_ng", 0, 0, 0, 1'b0, 0);
    cyc_a(3'b001, 3'b000, 1'b0);
    cyc_a(3'b001, 3'b001, 1'b0); push_a("play_again", 1, 0, 0, 1'b0, 0);
    cyc_a(3'b000, 3'b000, 1'b0);

    // Asynchronous reset between clock edges.
    #1 rst = 1'b1;
    #1 push_a("async_reset", 0, 0, 0, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Instance B: saturation at 9.
    for (int n = 1; n <= 9; n++) begin
      cyc_b(2'b01, 2'b01);
      if (n == 8) push_b("b_eight", 8, 0, 1'b0, 0);
      if (n == 9) push_b("b_nine_win", 9, 0, 1'b1, 1);
      cyc_b(2'b01, 2'b00);
    end
    cyc_b(2'b01, 2'b01);
    push_b("b_tenth_sat", 9, 0, 1'b1, 1);
    cyc_b(2'b00, 2'b00);

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
